// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants and writeback request type
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - writeback request valid/ready channel into the write queue
interface regfile_write_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/regfile_write_queue_fifo.sv
// rtl/regfile_write_queue_fifo.sv - wb_fifo: DEPTH-entry storage exposing every entry and its valid bit
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push_i,
  input  logic [W-1:0]              wdata_i,
  input  logic                      pop_i,
  output logic [W-1:0]              rdata_o,
  output logic [DEPTH-1:0][W-1:0]   entries_o,
  output logic [DEPTH-1:0]          valid_o,
  output logic [PTR_W-1:0]          rd_ptr_o,
  output logic [CNT_W-1:0]          count_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        off;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // An entry is live when its distance from the head is below the fill level.
  always_comb begin
    off     = '0;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, off} < count_q);
    end
  end

  assign rdata_o   = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - buffered register-file write initiator with in-flight detection
// Optional youngest-value forwarding is built when REGFILE_WRITE_QUEUE_BYPASS_EN is defined.
module regfile_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_queue_if.slave wb,
  input  logic [ADDR_W-1:0]    ra1,
  input  logic [ADDR_W-1:0]    ra2,
  output logic                 pend1,
  output logic                 pend2,
  output logic [DATA_W-1:0]    fwd1_data,
  output logic [DATA_W-1:0]    fwd2_data,
  output logic [ADDR_W-1:0]    wa,
  output logic [DATA_W-1:0]    wd,
  output logic                 regwrite,
  output logic [CNT_W-1:0]     count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam int W = ADDR_W + DATA_W;

  req_t                    head, wreq;
  logic [DEPTH-1:0][W-1:0] entries;
  logic [DEPTH-1:0]        valid;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_q;
  logic                    push, pop;
  logic [ADDR_W-1:0]       wa_q;
  logic [DATA_W-1:0]       wd_q;
  logic                    regwrite_q;

  // Ready is a pure function of fill level so upstream never sees a combinational loop.
  assign wb.in_ready = !reset && (count_q < CNT_W'(DEPTH));
  assign wreq        = '{addr: wb.in_addr, data: wb.in_data};
  assign push        = wb.in_valid && wb.in_ready && (wb.in_addr != ADDR_W'(ZERO_REG));
  assign pop         = (count_q != '0);

  wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .wdata_i   (wreq),
    .pop_i     (pop),
    .rdata_o   (head),
    .entries_o (entries),
    .valid_o   (valid),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wa_q       <= '0;
      wd_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (pop) begin
      wa_q       <= head.addr;
      wd_q       <= head.data;
      regwrite_q <= 1'b1;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign wa       = wa_q;
  assign wd       = wd_q;
  assign regwrite = regwrite_q;
  assign count    = count_q;

  req_t ent;

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    ent   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent = req_t'(entries[i]);
      if (valid[i] && ent.addr == ra1) pend1 = 1'b1;
      if (valid[i] && ent.addr == ra2) pend2 = 1'b1;
    end
    if (regwrite_q && wa_q == ra1) pend1 = 1'b1;
    if (regwrite_q && wa_q == ra2) pend2 = 1'b1;
    if (ra1 == ADDR_W'(ZERO_REG)) pend1 = 1'b0;
    if (ra2 == ADDR_W'(ZERO_REG)) pend2 = 1'b0;
  end

`ifdef REGFILE_WRITE_QUEUE_BYPASS_EN
  logic [PTR_W-1:0] idx;
  req_t             bent;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd1_data = '0;
    fwd2_data = '0;
    idx       = '0;
    bent      = '0;
    if (regwrite_q && wa_q == ra1) fwd1_data = wd_q;
    if (regwrite_q && wa_q == ra2) fwd2_data = wd_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = rd_ptr + PTR_W'(k);
      bent = req_t'(entries[idx]);
      if (valid[idx] && bent.addr == ra1) fwd1_data = bent.data;
      if (valid[idx] && bent.addr == ra2) fwd2_data = bent.data;
    end
    if (!pend1) fwd1_data = '0;
    if (!pend2) fwd2_data = '0;
  end
`else
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
